pe_array_sequencer: RTL
=======================

# pe_array_sequencer

Controller that sequences the binary PE array (`top`) through one full output-row computation. It pulls weights and activations from a valid/ready source stream and replays them to the array as `load_weight_in` / `in_valid_in` bursts, once per input channel. It then pops every partial sum into a valid/ready result stream with backpressure. It sits between the on-chip buffer/DMA and `top`, replacing the hand-timed phase sequencing the bench does today.

## Interface
- `O_CH`, 64, number of PE rows (weights per input channel, output channels)
- `I_CH`, 3, input channels accumulated per run
- `OUT_ROW_LENGTH`, 4, outputs per PE row (activations per input channel)
- `DATA_W`, 9, weight/activation word width
- `WIDTH`, 14, psum width
- `clk_in`  in  1  clock; single clock domain
- `rst_in`  in  1  synchronous, active-low reset
- `start_in`  in  1  begin a run; sampled only in IDLE
- `busy_out`  out  1  high from the cycle after an accepted start until `done_out`
- `done_out`  out  1  one-cycle pulse when the last result is accepted
- `src_valid_in` / `src_ready_out` / `src_data_in[DATA_W]`  source stream
- `pe_rst_out`  out  1  active-low clear to `top.rst_in`
- `pe_data_out`  out  DATA_W  to `top.data_in`
- `pe_load_weight_out`, `pe_in_valid_out`, `pe_pop_out`  out  1  to `top`
- `pe_sum_in`  in  WIDTH  from `top.sum_out`
- `res_valid_out` / `res_ready_in` / `res_data_out[WIDTH]` / `res_last_out`  result stream

## Operation
- States: IDLE → CLEAR → WEIGHT ⇄ ACT → SETTLE → POP → FLUSH → IDLE.
- IDLE: `start_in`=1 → CLEAR. `start_in` is ignored in every other state.
- CLEAR: one cycle with `pe_rst_out`=0, which zeroes the array psums. Then go to WEIGHT with `ch`=0.
- WEIGHT: `src_ready_out`=1. Count accepted beats. After the `O_CH`-th beat, go to ACT.
- ACT: `src_ready_out`=1. Count accepted beats. After the `OUT_ROW_LENGTH`-th beat:
  - if `ch`<`I_CH`-1: increment `ch` and go to WEIGHT;
  - otherwise go to SETTLE.
- `src_ready_out`=0 in every state except WEIGHT and ACT, so the source order is exactly `I_CH` × (`O_CH` weights then `OUT_ROW_LENGTH` activations).
- Each accepted beat is registered. In the next cycle, `pe_data_out` holds the data and exactly one of `pe_load_weight_out` (WEIGHT beat) or `pe_in_valid_out` (ACT beat) is high. When no beat was accepted, both strobes are 0 and `pe_data_out` holds its last value. Gaps between beats are legal.
- SETTLE: one cycle that lets the last `pe_in_valid_out` strobe land. Then go to POP.
- POP: `pe_pop_out` = (!`res_valid_out` || `res_ready_in`), combinational.
  - In each cycle `pe_pop_out`=1, `pe_sum_in` is captured into `res_data_out` and `res_valid_out` is set at the next edge.
  - After `O_CH`*`OUT_ROW_LENGTH` pops, go to FLUSH.
- Result order is the array's pop order: index i = o*`OUT_ROW_LENGTH`+col. `res_last_out`=1 with the final word.
- FLUSH: wait for the final word to be accepted. On that cycle pulse `done_out` and go to IDLE.
- Counter widths are `$clog2` of their terminal count; the pop counter is `$clog2(O_CH*OUT_ROW_LENGTH)`. Counters clear on entry to CLEAR.

## Timing
- Reset: state IDLE, all counters 0. Outputs during reset:
  - `pe_rst_out`=0;
  - `pe_data_out`=0;
  - all strobes, `res_valid_out`, `res_last_out`, `done_out`, `busy_out` and `src_ready_out` = 0;
  - `res_data_out`=0.
- After reset releases, `pe_rst_out`=1 except during CLEAR.
- Reset asserted mid-run aborts the run. All state returns to reset values at the next edge. No result or `done_out` is emitted.
- Beat-to-strobe latency is 1 cycle. Pop-to-`res_valid_out` latency is 1 cycle.
- Throughput: 1 beat/cycle into the array, 1 result/cycle out when unstalled.
- Minimum run with always-valid source and always-ready sink (defaults):
  - 1 (CLEAR) + 3*(64+4) + 1 (SETTLE) + 256 pops + 1 = 463 cycles from start to `done_out`.
- Backpressure holds `res_data_out` and `res_last_out` stable while `res_valid_out`=1 and `res_ready_in`=0. `pe_pop_out` stays 0 during that time, so the array's pop index does not advance.

## Configuration
- `PE_SEQ_PERF_EN` defined: adds two 32-bit outputs, both cleared at CLEAR and saturating at all-ones.
  - `perf_cycles_out`: cycles from the start of CLEAR to `done_out`.
  - `perf_stall_out`: cycles in WEIGHT/ACT with `src_valid_in`=0, plus cycles in POP/FLUSH with `res_valid_out`=1 and `res_ready_in`=0.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package `pe_array_pkg`:
  - state enum `pe_seq_state_t`;
  - default constants `O_CH`, `I_CH`, `OUT_ROW_LENGTH`, `DATA_W`, `WIDTH`, also used by `top` and the benches.
- One sub-module, `pe_seq_result_reg`: a single-entry valid/ready output register. It owns `res_*` and produces the pop-enable term.
- The FSM and counters live in `pe_array_sequencer`.

## Test plan
- Defaults, source always valid, sink always ready, bench data.dat stream → 256 results equal golden.dat in order; `res_last_out` only on index 255; `done_out` at cycle 463.
- Source deasserts `src_valid_in` every 3rd cycle → strobe count is exactly 192 weight and 12 activation strobes; results still match golden.
- Sink `res_ready_in` random 50% → no duplicated or dropped results; `res_data_out` stable while stalled; `pe_pop_out` count = 256.
- `rst_in`=0 for 1 cycle during the second ACT phase → all outputs at reset values next cycle. A fresh start then completes correctly with matching results.
- `start_in` pulsed while busy, and held high through `done_out` → the first is ignored; the held start begins exactly one new run after returning to IDLE.
- `PE_SEQ_PERF_EN` defined, stall-free run → `perf_cycles_out`=463, `perf_stall_out`=0.

Source files
------------

// File: rtl/pe_array_pkg.sv
// Shared definitions for the binary PE array and its sequencer: default
// array geometry, the sequencer state encoding and a counter-width helper.
package pe_array_pkg;

  localparam int O_CH           = 64;
  localparam int I_CH           = 3;
  localparam int OUT_ROW_LENGTH = 4;
  localparam int DATA_W         = 9;
  localparam int WIDTH          = 14;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WEIGHT = 3'd2,
    S_ACT    = 3'd3,
    S_SETTLE = 3'd4,
    S_POP    = 3'd5,
    S_FLUSH  = 3'd6
  } pe_seq_state_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_seq_result_reg.sv
// Single-entry valid/ready output register for the result stream.
// A word may be loaded whenever the slot is empty or being drained this
// cycle; load_en exposes exactly that so the array only pops when the
// word has somewhere to go.
module pe_seq_result_reg
  import pe_array_pkg::*;
#(
  parameter int W = pe_array_pkg::WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         ready,
  output logic         load_en,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last
);

  assign load_en = !valid || ready;

  // Capture on load, retire on handshake; data/last hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_array_sequencer.sv
// Sequences the binary PE array through one output-row computation:
// clear, I_CH rounds of (O_CH weights, OUT_ROW_LENGTH activations),
// settle, then drain O_CH*OUT_ROW_LENGTH psums into the result stream.
// Optional build macro PE_SEQ_PERF_EN adds cycle and stall counters.
//
// Handshake rule for both streams: a beat transfers on a rising edge where
// valid and ready are both high; valid must not depend on ready, and a
// producer holds data stable while valid is high and ready is low.
module pe_array_sequencer
  import pe_array_pkg::*;
#(
  parameter int O_CH           = pe_array_pkg::O_CH,
  parameter int I_CH           = pe_array_pkg::I_CH,
  parameter int OUT_ROW_LENGTH = pe_array_pkg::OUT_ROW_LENGTH,
  parameter int DATA_W         = pe_array_pkg::DATA_W,
  parameter int WIDTH          = pe_array_pkg::WIDTH
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic              busy_out,
  output logic              done_out,
  input  logic              src_valid_in,
  output logic              src_ready_out,
  input  logic [DATA_W-1:0] src_data_in,
  output logic              pe_rst_out,
  output logic [DATA_W-1:0] pe_data_out,
  output logic              pe_load_weight_out,
  output logic              pe_in_valid_out,
  output logic              pe_pop_out,
  input  logic [WIDTH-1:0]  pe_sum_in,
  output logic              res_valid_out,
  input  logic              res_ready_in,
  output logic [WIDTH-1:0]  res_data_out,
  output logic              res_last_out,
  output pe_seq_state_t     state_out
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles_out,
  output logic [31:0]       perf_stall_out
`endif
);

  localparam int WC_W = cnt_w(O_CH);
  localparam int AC_W = cnt_w(OUT_ROW_LENGTH);
  localparam int CH_W = cnt_w(I_CH);
  localparam int PC_W = cnt_w(O_CH * OUT_ROW_LENGTH);

  localparam logic [WC_W-1:0] W_LAST  = WC_W'(O_CH - 1);
  localparam logic [AC_W-1:0] A_LAST  = AC_W'(OUT_ROW_LENGTH - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(I_CH - 1);
  localparam logic [PC_W-1:0] P_LAST  = PC_W'(O_CH * OUT_ROW_LENGTH - 1);

  pe_seq_state_t   state;
  logic [WC_W-1:0] w_cnt;
  logic [AC_W-1:0] a_cnt;
  logic [CH_W-1:0] ch;
  logic [PC_W-1:0] p_cnt;

  logic beat;
  logic pop_en;
  logic pop_last;

  assign src_ready_out = (state == S_WEIGHT) || (state == S_ACT);
  assign beat          = src_valid_in && src_ready_out;
  assign pe_pop_out    = (state == S_POP) && pop_en;
  assign pop_last      = (p_cnt == P_LAST);
  assign busy_out      = (state != S_IDLE);
  assign done_out      = (state == S_FLUSH) && res_valid_out && res_ready_in;
  assign state_out     = state;

  // Phase FSM, beat/pop counters and the registered array-side outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state              <= S_IDLE;
      w_cnt              <= '0;
      a_cnt              <= '0;
      ch                 <= '0;
      p_cnt              <= '0;
      pe_rst_out         <= 1'b0;
      pe_data_out        <= '0;
      pe_load_weight_out <= 1'b0;
      pe_in_valid_out    <= 1'b0;
    end else begin
      // Every accepted beat is replayed to the array one cycle later.
      pe_load_weight_out <= beat && (state == S_WEIGHT);
      pe_in_valid_out    <= beat && (state == S_ACT);
      if (beat) pe_data_out <= src_data_in;
      // pe_rst_out is low exactly for the CLEAR cycle.
      pe_rst_out <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start_in) begin
            state      <= S_CLEAR;
            pe_rst_out <= 1'b0;
            w_cnt      <= '0;
            a_cnt      <= '0;
            ch         <= '0;
            p_cnt      <= '0;
          end
        end
        S_CLEAR: state <= S_WEIGHT;
        S_WEIGHT: begin
          if (beat) begin
            if (w_cnt == W_LAST) begin
              w_cnt <= '0;
              state <= S_ACT;
            end else begin
              w_cnt <= w_cnt + 1'b1;
            end
          end
        end
        S_ACT: begin
          if (beat) begin
            if (a_cnt == A_LAST) begin
              a_cnt <= '0;
              if (ch == CH_LAST) begin
                state <= S_SETTLE;
              end else begin
                ch    <= ch + 1'b1;
                state <= S_WEIGHT;
              end
            end else begin
              a_cnt <= a_cnt + 1'b1;
            end
          end
        end
        S_SETTLE: state <= S_POP;
        S_POP: begin
          if (pe_pop_out) begin
            p_cnt <= p_cnt + 1'b1;
            if (pop_last) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (done_out) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  pe_seq_result_reg #(.W(WIDTH)) u_res (
    .clk       (clk_in),
    .rst       (rst_in),
    .load      (pe_pop_out),
    .load_data (pe_sum_in),
    .load_last (pop_last),
    .ready     (res_ready_in),
    .load_en   (pop_en),
    .valid     (res_valid_out),
    .data      (res_data_out),
    .last      (res_last_out)
  );

`ifdef PE_SEQ_PERF_EN
  logic stall;
  assign stall = (src_ready_out && !src_valid_in) ||
                 (((state == S_POP) || (state == S_FLUSH)) &&
                  res_valid_out && !res_ready_in);

  // Run-length and stall counters, restarted by an accepted start.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      perf_cycles_out <= '0;
      perf_stall_out  <= '0;
    end else if ((state == S_IDLE) && start_in) begin
      perf_cycles_out <= '0;
      perf_stall_out  <= '0;
    end else begin
      if (busy_out && (perf_cycles_out != 32'hFFFF_FFFF))
        perf_cycles_out <= perf_cycles_out + 32'd1;
      if (stall && (perf_stall_out != 32'hFFFF_FFFF))
        perf_stall_out <= perf_stall_out + 32'd1;
    end
  end
`endif

endmodule
